// File: rtl/mem_stage_hilo.sv
// mem_stage_hilo: MIPS memory stage with byte-enable data memory, HI/LO accumulator
// and a one-entry registered write-back output with stall and misalignment detection.
module mem_stage_hilo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    input  logic              Stall,
    output logic              InReady,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemOp,
    input  logic [2:0]        HiLoOp,
    input  logic [1:0]        ResultSel,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] ALU_hi,
    input  logic [DATA_W-1:0] ReadReg1,
    input  logic [DATA_W-1:0] ReadReg2,
    input  logic              RegWriteIn,
    input  logic [REG_AW-1:0] WriteRegIn,
    output logic              OutValid,
    output logic [DATA_W-1:0] Result,
    output logic              RegWriteOut,
    output logic [REG_AW-1:0] WriteRegOut,
    output logic              AlignErr,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut
);
    localparam int NB = DATA_W / 8;
    localparam int L  = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d, res_q, res_d;
    logic                valid_q, rw_q, aerr_q;
    logic [REG_AW-1:0]   wreg_q;
    logic                accept, is_byte, is_half, is_word, misal, we;
    logic [L-1:0]        lane;
    logic [AW-1:0]       widx;
    logic [NB-1:0]       be;
    logic [DATA_W-1:0]   wdata, rd_shift, ld_data;
    logic [2*DATA_W-1:0] acc, opnd;

    assign InReady     = !Stall;
    assign accept      = InValid & !Stall;
    assign lane        = ALU_result[L-1:0];
    assign widx        = ALU_result[L+AW-1:L];
    assign is_half     = (MemOp == 3'b001) || (MemOp == 3'b010);
    assign is_byte     = (MemOp == 3'b011) || (MemOp == 3'b100);
    assign is_word     = !is_half && !is_byte;
    assign misal       = (MemRead | MemWrite) & (is_half ? lane[0] : (is_word & (|lane)));
    assign we          = accept & MemWrite & !misal;
    // Replicating the store data across lanes lets the byte enables pick the right slot.
    assign be          = is_byte ? ({{(NB-1){1'b0}}, 1'b1} << lane) :
                         is_half ? ({{(NB-2){1'b0}}, 2'b11} << lane) : '1;
    assign wdata       = is_byte ? {NB{ReadReg2[7:0]}} :
                         is_half ? {(NB/2){ReadReg2[15:0]}} : ReadReg2;
    assign rd_shift    = mem_q[widx] >> {lane, 3'b000};
    assign ld_data     = (MemOp == 3'b011) ? {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]} :
                         (MemOp == 3'b100) ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]} :
                         (MemOp == 3'b001) ? {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]} :
                         (MemOp == 3'b010) ? {{(DATA_W-16){1'b0}}, rd_shift[15:0]} : rd_shift;
    // HI/LO selections use the pre-update register values.
    assign res_d       = misal                ? '0 :
                         (ResultSel == 2'b01) ? ld_data :
                         (ResultSel == 2'b10) ? hi_q :
                         (ResultSel == 2'b11) ? lo_q : ALU_result;
    assign acc         = {hi_q, lo_q};
    assign opnd        = {ALU_hi, ALU_result};

    always_comb begin
        {hi_d, lo_d} = acc;
        if (accept) begin
            case (HiLoOp)
                3'b001:  hi_d = ReadReg1;
                3'b010:  lo_d = ReadReg1;
                3'b011:  {hi_d, lo_d} = opnd;
                3'b100:  {hi_d, lo_d} = acc + opnd;
                3'b101:  {hi_d, lo_d} = acc - opnd;
                default: {hi_d, lo_d} = acc;
            endcase
        end
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge Clk) begin
        if (we)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem_q[widx][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            aerr_q  <= 1'b0;
        end else if (!Stall) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= InValid;
            rw_q    <= InValid & RegWriteIn & !misal;
            aerr_q  <= InValid & misal;
            if (InValid) begin
                res_q  <= res_d;
                wreg_q <= WriteRegIn;
            end
        end
    end

    assign OutValid    = valid_q;
    assign Result      = res_q;
    assign RegWriteOut = rw_q;
    assign WriteRegOut = wreg_q;
    assign AlignErr    = aerr_q;
    assign HiOut       = hi_q;
    assign LoOut       = lo_q;
endmodule

// File: tb/tb_mem_stage_hilo.sv
// tb_mem_stage_hilo: randomized and directed checks of mem_stage_hilo against a
// byte-array / 64-bit accumulator reference model.
module tb_mem_stage_hilo;
    logic        Clk, Rst_n, InValid, Stall, InReady, MemRead, MemWrite, RegWriteIn;
    logic [2:0]  MemOp, HiLoOp;
    logic [1:0]  ResultSel;
    logic [31:0] ALU_result, ALU_hi, ReadReg1, ReadReg2, Result, HiOut, LoOut;
    logic [4:0]  WriteRegIn, WriteRegOut;
    logic        OutValid, RegWriteOut, AlignErr;

    mem_stage_hilo dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Stall(Stall), .InReady(InReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp), .HiLoOp(HiLoOp),
        .ResultSel(ResultSel), .ALU_result(ALU_result), .ALU_hi(ALU_hi),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .RegWriteIn(RegWriteIn),
        .WriteRegIn(WriteRegIn), .OutValid(OutValid), .Result(Result),
        .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut), .AlignErr(AlignErr),
        .HiOut(HiOut), .LoOut(LoOut)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    // Reference model: memory as a flat byte array, HI/LO as one 64-bit number.
    logic [7:0]  m_mem [4096];
    logic [63:0] m_hilo;
    logic        e_valid, e_rw, e_aerr;
    logic [31:0] e_res;
    logic [4:0]  e_wreg;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            chk("out_valid", {31'b0, OutValid}, {31'b0, e_valid});
            if (e_valid) begin
                chk("result", Result, e_res);
                chk("reg_write", {31'b0, RegWriteOut}, {31'b0, e_rw});
                chk("write_reg", {27'b0, WriteRegOut}, {27'b0, e_wreg});
                chk("align_err", {31'b0, AlignErr}, {31'b0, e_aerr});
            end
            chk("hi", HiOut, m_hilo[63:32]);
            chk("lo", LoOut, m_hilo[31:0]);
            chk("in_ready", {31'b0, InReady}, {31'b0, !Stall});
        end
    end

    task automatic drive(input bit v, st, mr, mw, input logic [2:0] mop, hop,
                         input logic [1:0] rs, input logic [31:0] alu, ahi, r1, r2,
                         input bit rw, input logic [4:0] wr);
        int size;
        logic [11:0] a, base;
        logic [31:0] ld;
        bit mis;
        @(negedge Clk);
        InValid = v; Stall = st; MemRead = mr; MemWrite = mw; MemOp = mop; HiLoOp = hop;
        ResultSel = rs; ALU_result = alu; ALU_hi = ahi; ReadReg1 = r1; ReadReg2 = r2;
        RegWriteIn = rw; WriteRegIn = wr;
        if (st) return;
        e_valid = v;
        e_rw = 0;
        e_aerr = 0;
        if (!v) return;
        a    = alu[11:0];
        base = {a[11:2], 2'b00};
        size = (mop == 1 || mop == 2) ? 2 : (mop == 3 || mop == 4) ? 1 : 4;
        mis  = (mr || mw) && (int'(a[1:0]) % size != 0);
        if (size == 1)
            ld = (mop == 3) ? 32'(signed'(m_mem[a])) : {24'b0, m_mem[a]};
        else if (size == 2)
            ld = (mop == 1) ? 32'(signed'({m_mem[a+1], m_mem[a]})) : {16'b0, m_mem[a+1], m_mem[a]};
        else
            ld = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
        e_res  = mis ? 0 : rs == 1 ? ld : rs == 2 ? m_hilo[63:32] : rs == 3 ? m_hilo[31:0] : alu;
        e_rw   = rw && !mis;
        e_aerr = mis;
        e_wreg = wr;
        if (mw && !mis)
            for (int k = 0; k < size; k++) m_mem[a + 12'(k)] = 8'(r2 >> (8 * k));
        case (hop)
            1: m_hilo[63:32] = r1;
            2: m_hilo[31:0]  = r1;
            3: m_hilo = {ahi, alu};
            4: m_hilo = m_hilo + {ahi, alu};
            5: m_hilo = m_hilo - {ahi, alu};
            default: ;
        endcase
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic sw(input logic [31:0] addr, data);
        drive(1, 0, 0, 1, 0, 0, 0, addr, 0, 0, data, 0, 0);
    endtask
    task automatic ld_op(input logic [2:0] mop, input logic [31:0] addr);
        drive(1, 0, 1, 0, mop, 0, 1, addr, 0, 0, 0, 1, 5'd7);
    endtask
    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Rst_n = 0; InValid = 0; Stall = 0; MemRead = 0; MemWrite = 0; MemOp = 0; HiLoOp = 0;
        ResultSel = 0; ALU_result = 0; ALU_hi = 0; ReadReg1 = 0; ReadReg2 = 0;
        RegWriteIn = 0; WriteRegIn = 0;
        m_hilo = 0; e_valid = 0; e_rw = 0; e_aerr = 0; e_res = 0; e_wreg = 0;
        repeat (2) @(posedge Clk);
        #2;
        chk("rst_valid", {31'b0, OutValid}, 0);
        chk("rst_result", Result, 0);
        chk("rst_hi", HiOut, 0);
        chk("rst_lo", LoOut, 0);
        chk("rst_rw", {31'b0, RegWriteOut}, 0);
        chk("rst_wreg", {27'b0, WriteRegOut}, 0);
        chk("rst_aerr", {31'b0, AlignErr}, 0);
        @(negedge Clk);
        Rst_n = 1;
        chk_en = 1;

        for (int i = 0; i < 64; i++) sw(i * 4, $urandom);
        sw(32'h10, 32'hDEADBEEF);
        ld_op(0, 32'h10);
        settle();
        chk("lw_result", Result, 32'hDEADBEEF);
        chk("lw_valid", {31'b0, OutValid}, 1);
        chk("lw_rw", {31'b0, RegWriteOut}, 1);

        sw(32'h20, 32'h80FF7F01);
        ld_op(3, 32'h23); settle(); chk("lb", Result, 32'hFFFFFF80);
        ld_op(4, 32'h23); settle(); chk("lbu", Result, 32'h00000080);
        ld_op(1, 32'h22); settle(); chk("lh", Result, 32'hFFFF80FF);
        ld_op(2, 32'h20); settle(); chk("lhu", Result, 32'h00007F01);
        ld_op(0, 32'h22); settle();
        chk("mis_aerr", {31'b0, AlignErr}, 1);
        chk("mis_rw", {31'b0, RegWriteOut}, 0);
        chk("mis_result", Result, 0);
        drive(1, 0, 0, 1, 1, 0, 0, 32'h21, 0, 0, 32'h5555, 0, 0);
        ld_op(0, 32'h20); settle(); chk("sh_mis_mem", Result, 32'h80FF7F01);

        drive(1, 0, 0, 0, 0, 3, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 4, 0, 32'h1, 0, 0, 0, 0, 0);
        settle();
        chk("madd_hi", HiOut, 1);
        chk("madd_lo", LoOut, 0);
        drive(1, 0, 0, 0, 0, 5, 3, 32'h2, 0, 0, 0, 1, 5'd3);
        settle();
        chk("msub_res_old_lo", Result, 0);
        chk("msub_hi", HiOut, 0);
        chk("msub_lo", LoOut, 32'hFFFFFFFE);

        repeat (3) begin
            drive(1, 1, 0, 1, 0, 1, 0, 32'h30, 0, 32'hABCD, 32'h11223344, 0, 0);
            settle();
            chk("stall_ready", {31'b0, InReady}, 0);
            chk("stall_hi", HiOut, 0);
        end
        drive(1, 0, 0, 1, 0, 1, 0, 32'h30, 0, 32'hABCD, 32'h11223344, 0, 0);
        ld_op(0, 32'h30);
        settle();
        chk("stall_sw", Result, 32'h11223344);
        chk("stall_hi_rel", HiOut, 32'hABCD);

        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1234, 0, 0, 0);
        @(posedge Clk);
        #3;
        chk("pre_rst_hi", HiOut, 32'h1234);
        chk("pre_rst_valid", {31'b0, OutValid}, 1);
        Rst_n = 0;
        #1;
        chk("async_rst_hi", HiOut, 0);
        chk("async_rst_valid", {31'b0, OutValid}, 0);
        m_hilo = 0; e_valid = 0; e_rw = 0; e_aerr = 0;
        idle();
        Rst_n = 1;
        ld_op(0, 32'h30); settle(); chk("mem_kept", Result, 32'h11223344);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] alu;
            bit mr, mw;
            logic [1:0] rs;
            alu = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFF000) : 32'h0) | 32'($urandom_range(0, 255));
            mr  = $urandom_range(0, 2) == 0;
            mw  = $urandom_range(0, 3) == 0;
            rs  = 2'($urandom_range(0, 3));
            if (!mr && rs == 1) rs = 2'b11;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, mr, mw,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rs, alu,
                  $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
        end
        idle();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_hilo.md
Name: mem_stage_hilo

Overview:
- Parametrised next-generation MIPS memory stage.
- Combines the following in one block:
  - a synchronous byte-addressable data memory with byte/half/word access and sign/zero extension;
  - a HI/LO register pair with write, 64-bit load, MADD and MSUB modes;
  - a registered result selector feeding write-back.
- Adds a one-entry output pipeline register with stall, misalignment detection and defined HI/LO read-before-write semantics.
- Sits between the execute stage (ALU_result/ALU_hi) and the register-file write port.

Parameters:
DATA_W, 32, datapath and memory word width in bits; legal values 32 or 64.
DEPTH, 1024, memory depth in words; power of two.
REG_AW, 5, register-file destination index width.

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
InValid  input  1  instruction present at stage inputs
Stall  input  1  downstream stall; freezes the stage
InReady  output  1  equals !Stall; upstream holds inputs while 0
MemRead  input  1  load instruction
MemWrite  input  1  store instruction
MemOp  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others behave as word
HiLoOp  input  3  000 none, 001 HI<=Rs, 010 LO<=Rs, 011 {HI,LO}<={ALU_hi,ALU_result}, 100 {HI,LO}+= {ALU_hi,ALU_result}, 101 {HI,LO}-= {ALU_hi,ALU_result}; others none
ResultSel  input  2  00 ALU_result, 01 load data, 10 HI, 11 LO
ALU_result  input  DATA_W  address for memory ops / low product / ALU value
ALU_hi  input  DATA_W  high half of product
ReadReg1  input  DATA_W  Rs value for MTHI/MTLO
ReadReg2  input  DATA_W  Rt value (store data)
RegWriteIn  input  1  instruction writes register file
WriteRegIn  input  REG_AW  destination register
OutValid  output  1  Result/WriteRegOut valid this cycle
Result  output  DATA_W  write-back value
RegWriteOut  output  1  register write enable to WB
WriteRegOut  output  REG_AW  destination register to WB
AlignErr  output  1  accepted instruction was a misaligned memory access
HiOut  output  DATA_W  current HI register
LoOut  output  DATA_W  current LO register

Behaviour:
- Accept condition is InValid & !Stall. Non-accepted cycles have:
  - no store;
  - no HI/LO change;
  - OutValid <= 0 when !Stall.
- Stall=1 holds every output register, including OutValid, and blocks all writes.
- Latency is 1 cycle. Values for an instruction accepted at edge N appear on the outputs after edge N; there is no combinational path from inputs to Result.
- Address decode: L = log2(DATA_W/8).
  - byte lane = ALU_result[L-1:0]
  - word index = ALU_result[L+log2(DEPTH)-1 : L]
  - Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Alignment:
  - half requires lane bit 0 = 0;
  - word requires all lane bits = 0;
  - byte is always aligned.
  - A misaligned MemRead or MemWrite gives: store suppressed, AlignErr=1, RegWriteOut=0, Result=0, OutValid=1, HI/LO still updated per HiLoOp.
- Stores: written at the accept edge.
  - byte store uses ReadReg2[7:0] into the selected lane;
  - half store uses ReadReg2[15:0] into lanes lane, lane+1;
  - word store writes the full word;
  - other lanes are unchanged (byte-enable write).
  - Signed and unsigned store encodings behave identically.
- Loads: synchronous read at the accept edge. The selected byte/half is right-justified, then sign- or zero-extended to DATA_W.
- Load/store same address in back-to-back accepted instructions: the load returns the newly stored data, because the store edge precedes the read edge.
- A single instruction with both MemRead and MemWrite: the store happens and the load returns the old data (read-before-write).
- HI/LO arithmetic is 2*DATA_W bits modulo 2^(2*DATA_W): {HI,LO} +/- {ALU_hi,ALU_result}, with no saturation and no overflow flag.
- ResultSel 10/11 returns the HI/LO value before the same instruction's HiLoOp update.
- An instruction accepted immediately after a HI/LO update sees the updated value, with no hazard bubble.
- RegWriteOut <= RegWriteIn & !AlignErr_next. WriteRegOut <= WriteRegIn.
- Reset (asynchronous, Rst_n=0), effective immediately and mid-stall:
  - HI=LO=0;
  - OutValid=0, Result=0, RegWriteOut=0, WriteRegOut=0, AlignErr=0;
  - memory contents are not reset.
  - A store in flight at reset assertion is not guaranteed.
- InReady is purely combinational: !Stall.

Test Plan:
- Word store/load, DATA_W=32: SW 0xDEADBEEF @0x10, then LW @0x10 with ResultSel=01 -> Result=0xDEADBEEF, OutValid=1 one cycle after accept, RegWriteOut=1.
- Byte/half extension: mem[0x20]=0x80FF7F01.
  - LB @0x23 -> 0xFFFFFF80
  - LBU @0x23 -> 0x00000080
  - LH @0x22 -> 0xFFFF80FF
  - LHU @0x20 -> 0x00007F01
- Misalignment: LW @0x22 -> AlignErr=1, RegWriteOut=0, Result=0. SH @0x21 -> mem[0x20] unchanged.
- HI/LO accumulate:
  - HiLoOp=011 with {0x00000000,0xFFFFFFFF}, then HiLoOp=100 with {0,1} -> HI=1, LO=0.
  - Then HiLoOp=101 with {0,2} -> HI=0, LO=0xFFFFFFFE.
  - An instruction with ResultSel=11 issued in the same cycle as that 101 returns 0.
- Stall: assert Stall for 3 cycles while an SW and a HiLoOp=001 are presented -> memory and HI unchanged, outputs frozen, InReady=0. Release -> SW and HiLoOp take effect once.
- Reset mid-operation: Rst_n low between clocks after HI=0x1234 -> HI=0 and OutValid=0 immediately. Memory data written earlier is still readable after reset release.
